// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_queue
// Purpose : Byte FIFO that drains into a UART using a free/transmit handshake.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH = 16,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [ABITS:0]   level,
    output logic             overflow,
    input  logic             uart_tx_free,
    output logic             uart_transmit,
    output logic [7:0]       uart_tx_byte,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_FREE = 2'd3
    } state_t;

    localparam logic [ABITS-1:0] c_ptr_one    = ABITS'(1);
    localparam logic [ABITS:0]   c_level_one  = (ABITS + 1)'(1);
    localparam logic [ABITS:0]   c_level_full = (ABITS + 1)'(DEPTH);

    logic [7:0]       fifo_mem [DEPTH];

    state_t           state_q, state_d;
    logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ABITS:0]   level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             push;
    logic             pop;

    // A pop in the same cycle never frees room for a write: push looks at full_q only.
    always_comb begin
        push       = wr_en && !flush && !full_q;
        pop        = (state_q == IDLE) && !empty_q && uart_tx_free;
        overflow_d = wr_en && !flush && full_q;

        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = LAUNCH;
                    tx_byte_d = fifo_mem[rd_ptr_q];
                end
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (!uart_tx_free) state_d = WAIT_FREE;
            WAIT_FREE: if (uart_tx_free) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + c_ptr_one;
            if (pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
            if (push && !pop)      level_d = level_q + c_level_one;
            else if (!push && pop) level_d = level_q - c_level_one;
        end

        full_d  = (level_d == c_level_full);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign uart_transmit = (state_q == LAUNCH);
    assign uart_tx_byte  = tx_byte_q;
    assign busy          = (state_q != IDLE);

endmodule
`default_nettype wire
